// File: rtl/dfe_out_fifo.sv
// dfe_out_fifo: FWFT output elastic buffer behind the DFE core output.
// Optional macro DFE_OUT_FIFO_SAT_EN saturates flagged samples at push.
module dfe_out_fifo #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int AFULL_THRESH   = 12,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      ovf_in,
    input  logic                      unf_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [1:0]                m_flags,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      almost_full,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      sticky_drop,
    input  logic                      clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_THRESH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] last_q;
    logic [EW-1:0] head;
    logic [EW-1:0] wr_entry;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LW-1:0] level_nxt;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          cnt_sat;

    assign full    = (level == FULL_LVL);
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign push    = valid_in & (~full | pop);
    assign drop    = valid_in & full & ~pop;
    assign cnt_sat = &drop_cnt;

    // Once empty, keep presenting the last entry handed out.
    assign head    = m_valid ? mem[rd_ptr] : last_q;
    assign m_data  = head[DATA_WIDTH-1:0];
    assign m_flags = head[EW-1:DATA_WIDTH];

`ifdef DFE_OUT_FIFO_SAT_EN
    localparam logic [DATA_WIDTH-1:0] MAX_POS =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        wr_data = data_in;
        if (ovf_in)
            wr_data = MAX_POS;
        else if (unf_in)
            wr_data = MIN_NEG;
    end
`else
    assign wr_data = data_in;
`endif

    assign wr_entry = {ovf_in, unf_in, wr_data};

    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            last_q      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            level       <= level_nxt;
            almost_full <= (level_nxt >= AF_LVL);
        end
    end

    // A drop in the same cycle as clr_err is kept as a fresh event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt    <= '0;
            sticky_drop <= 1'b0;
        end else if (drop) begin
            sticky_drop <= 1'b1;
            if (clr_err)
                drop_cnt <= DROP_CNT_WIDTH'(1);
            else if (!cnt_sat)
                drop_cnt <= drop_cnt + 1'b1;
        end else if (clr_err) begin
            drop_cnt    <= '0;
            sticky_drop <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dfe_out_fifo.sv
// tb_dfe_out_fifo: directed self-checking bench for dfe_out_fifo.
// Runs with DROP_CNT_WIDTH=4 so counter saturation is reachable.
module tb_dfe_out_fifo;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ovf_in;
    logic        unf_in;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  m_flags;
    logic [4:0]  level;
    logic        almost_full;
    logic [3:0]  drop_cnt;
    logic        sticky_drop;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    dfe_out_fifo #(
        .DATA_WIDTH(16),
        .DEPTH(16),
        .AFULL_THRESH(12),
        .DROP_CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .data_in(data_in),
        .ovf_in(ovf_in),
        .unf_in(unf_in),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_flags(m_flags),
        .level(level),
        .almost_full(almost_full),
        .drop_cnt(drop_cnt),
        .sticky_drop(sticky_drop),
        .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_ovf;
    logic [15:0] exp_unf;

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        ovf_in = 1'b0;
        unf_in = 1'b0;
        m_ready = 1'b0;
        clr_err = 1'b0;
        step();
        step();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_flags", 32'(m_flags), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_sticky", 32'(sticky_drop), 32'd0);
        rst = 1'b0;
        step();

        // Basic ordering, one-cycle latency
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_in = 1'b1;
            data_in = 16'(i);
            step();
            chk("ord_m_valid", 32'(m_valid), 32'd1);
            chk("ord_m_data", 32'(m_data), 32'(i));
            chk("ord_level", 32'(level), 32'd1);
        end
        valid_in = 1'b0;
        step();
        chk("ord_empty_valid", 32'(m_valid), 32'd0);
        chk("ord_empty_level", 32'(level), 32'd0);
        chk("ord_hold_data", 32'(m_data), 32'h5);
        chk("ord_flags", 32'(m_flags), 32'd0);
        step();
        chk("empty_pop_level", 32'(level), 32'd0);

        // Fill, watermark, drop
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1;
            data_in = 16'h1000 + 16'(i);
            step();
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_afull", 32'(almost_full),
                (i + 1 >= 12) ? 32'd1 : 32'd0);
        end
        data_in = 16'hBEEF;
        step();
        chk("drop_level", 32'(level), 32'd16);
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        chk("drop_sticky", 32'(sticky_drop), 32'd1);
        valid_in = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(m_data), 32'h1000 + 32'(i));
            step();
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_afull", 32'(almost_full), 32'd0);

        // Full with simultaneous pop
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1;
            data_in = 16'h3000 + 16'(i);
            step();
        end
        data_in = 16'h2222;
        m_ready = 1'b1;
        step();
        chk("fp_level", 32'(level), 32'd16);
        chk("fp_no_drop", 32'(drop_cnt), 32'd1);
        valid_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("fp_data", 32'(m_data),
                (i < 15) ? 32'h3001 + 32'(i) : 32'h2222);
            step();
        end
        chk("fp_empty", 32'(level), 32'd0);

        // Error clear race
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1;
            data_in = 16'h4000 + 16'(i);
            step();
        end
        chk("race_cnt5", 32'(drop_cnt), 32'd5);
        valid_in = 1'b0;
        clr_err = 1'b1;
        step();
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_sticky", 32'(sticky_drop), 32'd0);
        valid_in = 1'b1;
        step();
        chk("race_cnt", 32'(drop_cnt), 32'd1);
        chk("race_sticky", 32'(sticky_drop), 32'd1);
        clr_err = 1'b0;

        // Counter saturation
        for (int j = 1; j <= 20; j++) begin
            step();
            chk("sat_cnt", 32'(drop_cnt),
                (j + 1 > 15) ? 32'd15 : 32'(j + 1));
        end
        valid_in = 1'b0;

        // Reset mid-stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1;
            data_in = 16'h5000 + 16'(i);
            step();
        end
        valid_in = 1'b0;
        chk("mid_level7", 32'(level), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        valid_in = 1'b1;
        data_in = 16'h0ABC;
        step();
        valid_in = 1'b0;
        chk("mid_first_valid", 32'(m_valid), 32'd1);
        chk("mid_first_data", 32'(m_data), 32'h0ABC);
        chk("mid_first_level", 32'(level), 32'd1);
        m_ready = 1'b1;
        step();
        chk("mid_drained", 32'(level), 32'd0);

        // Flag handling and optional saturation
`ifdef DFE_OUT_FIFO_SAT_EN
        exp_ovf = 16'h7FFF;
        exp_unf = 16'h8000;
`else
        exp_ovf = 16'h1234;
        exp_unf = 16'h1234;
`endif
        m_ready = 1'b0;
        valid_in = 1'b1;
        data_in = 16'h1234;
        ovf_in = 1'b1;
        step();
        chk("sat_ovf_data", 32'(m_data), 32'(exp_ovf));
        chk("sat_ovf_flags", 32'(m_flags), 32'h2);
        m_ready = 1'b1;
        ovf_in = 1'b0;
        unf_in = 1'b1;
        step();
        chk("sat_unf_data", 32'(m_data), 32'(exp_unf));
        chk("sat_unf_flags", 32'(m_flags), 32'h1);
        ovf_in = 1'b1;
        step();
        chk("sat_both_data", 32'(m_data), 32'(exp_ovf));
        chk("sat_both_flags", 32'(m_flags), 32'h3);
        valid_in = 1'b0;
        ovf_in = 1'b0;
        unf_in = 1'b0;
        step();
        chk("sat_end_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
